// File: rtl/ser_stream.sv
// ser_stream: parallel-to-serial converter with per-word length/bit order and a one-word pending buffer
module ser_stream #(
  parameter int DATA_W  = 16,
  parameter int LEN_W   = $clog2(DATA_W),
  parameter int MIN_LEN = 3
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  data_mod_i,
  input  logic              data_msb_first_i,
  input  logic              data_val_i,
  output logic              data_ready_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              ser_last_o,
  output logic              busy_o,
  output logic              drop_o
);
  localparam logic [LEN_W:0] FULL = (LEN_W+1)'(DATA_W);
  localparam logic [LEN_W:0] MIN  = (LEN_W+1)'(MIN_LEN);
  localparam logic [LEN_W:0] ONE  = (LEN_W+1)'(1);
  logic [DATA_W-1:0] sh_data, pend_data, cur_data;
  logic [LEN_W:0]    sh_cnt, pend_len, in_len, cnt_n;
  logic              sh_msb, pend_msb, pend_valid, cur_msb;
  logic              acc, legal, free, take_pend, bypass, pend_wr, pend_valid_n;
  assign data_ready_o = !pend_valid && !srst_i;
  assign in_len       = (data_mod_i == '0) ? FULL : {1'b0, data_mod_i};
  assign acc          = data_val_i && data_ready_o;
  assign legal        = in_len >= MIN;
  // sh_cnt counts bits still to show, including the one on the output now; the shifter
  // is free when it is empty or presenting its last bit, and then reloads pending first, else bypass
  always_comb begin
    free         = sh_cnt <= ONE;
    take_pend    = free && pend_valid;
    bypass       = free && !pend_valid && acc && legal;
    pend_wr      = acc && legal && !bypass;
    cur_data     = take_pend ? pend_data : bypass ? data_i : sh_data;
    cur_msb      = take_pend ? pend_msb : bypass ? data_msb_first_i : sh_msb;
    cnt_n        = take_pend ? pend_len : bypass ? in_len : free ? '0 : sh_cnt - ONE;
    pend_valid_n = pend_valid ? !free : pend_wr;
  end
  // state and registered outputs; the next bit is taken from the edge of cur_data and the rest shifted in place
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sh_data        <= '0;
      sh_cnt         <= '0;
      sh_msb         <= 1'b0;
      pend_data      <= '0;
      pend_len       <= '0;
      pend_msb       <= 1'b0;
      pend_valid     <= 1'b0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      ser_last_o     <= 1'b0;
      busy_o         <= 1'b0;
      drop_o         <= 1'b0;
    end else begin
      sh_data        <= cur_msb ? cur_data << 1 : cur_data >> 1;
      sh_cnt         <= cnt_n;
      sh_msb         <= cur_msb;
      pend_valid     <= pend_valid_n;
      if (pend_wr) begin
        pend_data <= data_i;
        pend_len  <= in_len;
        pend_msb  <= data_msb_first_i;
      end
      ser_data_o     <= (cnt_n != '0) && (cur_msb ? cur_data[DATA_W-1] : cur_data[0]);
      ser_data_val_o <= cnt_n != '0;
      ser_last_o     <= cnt_n == ONE;
      busy_o         <= (cnt_n != '0) || pend_valid_n;
      drop_o         <= acc && !legal;
    end
  end
endmodule

// File: doc/ser_stream.md
# ser_stream

Parametrised successor to the team's fixed 16-bit serializer. It accepts parallel words of `DATA_W` bits with a per-word bit length and bit-order mode, and emits them one bit per clock with a valid/last qualifier. A one-word pending buffer with a ready handshake lets back-to-back words stream with no idle cycle between them. The block sits between a word-oriented producer and a bit-serial line driver.

## Interface
- `DATA_W`, default 16: word width; must be a power of two, at least 4.
- `LEN_W`, default `$clog2(DATA_W)`: width of `data_mod_i`; derived, do not override.
- `MIN_LEN`, default 3: shortest legal length; shorter words are dropped. Range 1..`DATA_W`.
- `clk_i`, in, 1: single clock; all logic is on the rising edge.
- `srst_i`, in, 1: synchronous reset, active-high.
- `data_i`, in, `DATA_W`: parallel word.
- `data_mod_i`, in, `LEN_W`: bit count; 0 means `DATA_W`.
- `data_msb_first_i`, in, 1: 1 sends MSB-first; 0 sends LSB-first.
- `data_val_i`, in, 1: the word on `data_i` is valid.
- `data_ready_o`, out, 1: the block can accept a word; a transfer occurs when `data_val_i & data_ready_o`.
- `ser_data_o`, out, 1: serial bit; 0 whenever `ser_data_val_o` is 0.
- `ser_data_val_o`, out, 1: `ser_data_o` is valid.
- `ser_last_o`, out, 1: the current bit is the last bit of its word.
- `busy_o`, out, 1: the shifter or the pending buffer holds a word.
- `drop_o`, out, 1: one-cycle pulse when an accepted word has an illegal length.

## Operation
- **Length decode.** `len = (data_mod_i == 0) ? DATA_W : data_mod_i`. The word is legal when `len >= MIN_LEN`.
- **Illegal words.** An accepted word with an illegal length is discarded and produces no serial output. `drop_o` is high the cycle after acceptance.
- **Storage.** Two registers:
  - shifter: word, remaining-bit counter, order flag.
  - pending: one word plus its length and mode, with a valid flag.
- **Ready.** `data_ready_o = !pend_valid && !srst_i`. It is a combinational function of registered state only and never depends on `data_val_i`.
- **Shifter becomes free at an edge when:**
  - the shifter is empty, or
  - the shifter is emitting its last bit in the current cycle.
- **Load at each edge where the shifter is free:**
  - If pending is valid, load the shifter from pending.
  - Otherwise, if a legal word is accepted this cycle, load it directly (bypass).
  - Otherwise, the shifter becomes empty.
- **Pending write.** A legal accepted word that is not bypassed into the shifter is written to pending. This cannot collide with a full pending buffer, because ready is low then.
- **Bit order, for a word of length `len`:**
  - MSB-first: `data[DATA_W-1]` down to `data[DATA_W-len]`.
  - LSB-first: `data[0]` up to `data[len-1]`.
  - Bits outside the selected range are ignored.
- **Mode capture.** Mode and length are captured with the word. Changing inputs after acceptance has no effect.
- **Output registers.** All outputs except `data_ready_o` are registered:
  - `ser_data_val_o` is high for exactly `len` consecutive cycles per legal word.
  - `ser_last_o` is high on the final one of those cycles.
- **Busy.** `busy_o = shifter_active || pend_valid`, registered-equivalent.

## Timing
- **Reset values:** `ser_data_o` = 0, `ser_data_val_o` = 0, `ser_last_o` = 0, `busy_o` = 0, `drop_o` = 0. Pending and shifter are empty and the counter is 0.
- **`data_ready_o` around reset:** 0 while `srst_i` is high; 1 in the first cycle after reset.
- **Latency:** a word accepted at edge E, with an idle block, drives its first bit in the cycle following E.
- **Back-to-back words:** the first bit of word N+1 directly follows the `ser_last_o` cycle of word N. There is no gap, provided word N+1 was accepted no later than that `ser_last_o` cycle.
- **Sustained streaming:**
  - With `len = DATA_W`, ready is high 1 cycle in every `DATA_W` in steady state.
  - With `len = MIN_LEN`, throughput is still 1 bit per cycle.
- **Pending freed by last bit:** when the shifter emits its last bit and loads from pending at that edge, ready is high the next cycle.
- **Simultaneous events:** acceptance in the same cycle the last bit is emitted, with pending empty, takes the bypass and produces no gap.
- **Illegal word while busy:** it is dropped. Pending and shifter are unaffected, and there is no bubble in the serial output.
- **Reset mid-word:** all words in flight are discarded. Outputs return to their reset values at the next edge, and no partial word resumes.
- **Counter width:** `LEN_W+1` bits so that `DATA_W` is representable. There is no wrap-around on load.

## Test plan
- **Basic MSB-first:** `DATA_W=16`, `data_i=16'hA5C3`, mode 0 (16 bits), MSB-first, idle block → bits 1010_0101_1100_0011 on 16 consecutive cycles starting 1 cycle after acceptance; `ser_last_o` on cycle 16; `busy_o` falls after it.
- **LSB-first partial:** `data_i=16'h00B6`, mode 5, LSB-first → bits 0,1,1,0,1; `ser_last_o` on the 5th bit; no further valid bits.
- **Illegal lengths:** modes 1 and 2 with `MIN_LEN=3` → each is accepted with `ready=1`, `drop_o` pulses once, and `ser_data_val_o` stays 0.
- **Back-to-back stream:** `data_val_i` held high with 8 words of mode 3 → 24 contiguous valid cycles with no gap; `ser_last_o` on every 3rd cycle; ready deasserts while pending is full.
- **Simultaneous accept and last bit:** accept a word exactly on the `ser_last_o` cycle with pending empty → the new first bit appears in the next cycle.
- **Reset mid-word:** assert `srst_i` on bit 7 of a 16-bit word → all outputs are 0 the next cycle, `data_ready_o` is 1 the cycle after reset deasserts, and a fresh word serializes correctly.
